division_unit: RTL and testbench

- Sequential IEEE-754 single-precision divider, dataR = dataA / dataB.
- Inverse companion of the combinational multiplier unit in the same FP datapath.
- Uses the same special-case flag encoding and the same flush-to-zero treatment of denormals.
- Iterative restoring mantissa division, one quotient bit per clock, start/busy/done handshake, truncating (no rounding).

---
 rtl/fp_div_pkg.sv | 36 +++
 rtl/mant_divider_iter.sv | 53 +++++
 rtl/division_unit.sv | 156 +++++++++++++++
 tb/tb_division_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// Special-case flags match the multiplier unit in the same FP datapath.
package fp_div_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StDiv,
        StNorm,
        StDone
    } div_state_e;

    localparam int EXP_BIAS = 127;

    localparam logic [3:0] CASE_ZERO = 4'b1000;
    localparam logic [3:0] CASE_PINF = 4'b0100;
    localparam logic [3:0] CASE_NINF = 4'b0010;
    localparam logic [3:0] CASE_NAN  = 4'b0001;
    localparam logic [3:0] CASE_NONE = 4'b0000;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Denormals are flushed: any zero exponent classifies as zero.
    function automatic fp_class_t classify(input logic [30:0] mag);
        fp_class_t c;
        c.is_zero = (mag[30:23] == 8'h00);
        c.is_inf  = (mag[30:23] == 8'hFF) && (mag[22:0] == 23'd0);
        c.is_nan  = (mag[30:23] == 8'hFF) && (mag[22:0] != 23'd0);
        return c;
    endfunction

endpackage

// File: rtl/mant_divider_iter.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
// last_o is high during the step that produces the final quotient bit.
module mant_divider_iter #(
    parameter int unsigned QBITS = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [23:0]      dividend_i,
    input  logic [23:0]      divisor_i,
    output logic [QBITS-1:0] quot_o,
    output logic             last_o
);

    localparam int unsigned CntW = $clog2(QBITS);

    // Remainder needs one extra bit: after a shift it can reach 2*divisor-2.
    logic [24:0]      rem_q;
    logic [23:0]      div_q;
    logic [QBITS-1:0] quot_q;
    logic [CntW-1:0]  cnt_q;
    logic             ge;
    logic [23:0]      diff;

    assign ge   = (rem_q >= {1'b0, div_q});
    // When ge holds, the difference is below the divisor, so 24 bits suffice.
    assign diff = rem_q[23:0] - div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            rem_q  <= {1'b0, dividend_i};
            div_q  <= divisor_i;
            quot_q <= '0;
            cnt_q  <= CntW'(QBITS - 1);
        end else if (step_i) begin
            quot_q <= {quot_q[QBITS-2:0], ge};
            rem_q  <= ge ? {diff, 1'b0} : {rem_q[23:0], 1'b0};
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    assign quot_o = quot_q;
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/division_unit.sv
// Sequential IEEE-754 single-precision divider, dataR = dataA / dataB.
// Truncating, denormals flushed to zero, start/busy/done handshake.
module division_unit
    import fp_div_pkg::*;
#(
    parameter int unsigned QBITS       = 25,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataR,
    output logic [3:0]  casesspecial
);

    div_state_e         state_q;
    logic [31:0]        opa_q;
    logic [31:0]        opb_q;
    logic signed [9:0]  expw_q;

    fp_class_t          ca;
    fp_class_t          cb;
    logic               sign;
    logic               spec_hit;
    logic [31:0]        spec_r;
    logic [3:0]         spec_c;
    logic signed [9:0]  expw_calc;

    logic [QBITS-1:0]   quot;
    logic               div_last;
    logic               div_load;
    logic               div_step;

    logic signed [9:0]  exp_n;
    logic [22:0]        mant_n;
    logic [31:0]        norm_r;
    logic [3:0]         norm_c;

    assign sign = opa_q[31] ^ opb_q[31];

    // Special-case resolution in priority order: NaN, then Inf, then zero.
    always_comb begin
        ca       = classify(opa_q[30:0]);
        cb       = classify(opb_q[30:0]);
        spec_hit = 1'b1;
        spec_r   = NAN_PATTERN;
        spec_c   = CASE_NAN;
        if (ca.is_nan || cb.is_nan || (ca.is_inf && cb.is_inf) ||
            (ca.is_zero && cb.is_zero)) begin
            spec_r = NAN_PATTERN;
            spec_c = CASE_NAN;
        end else if (ca.is_inf || cb.is_zero) begin
            spec_r = {sign, 8'hFF, 23'd0};
            spec_c = sign ? CASE_NINF : CASE_PINF;
        end else if (ca.is_zero || cb.is_inf) begin
            spec_r = {sign, 31'd0};
            spec_c = CASE_ZERO;
        end else begin
            spec_hit = 1'b0;
        end
    end

    assign expw_calc = $signed({2'b00, opa_q[30:23]}) - $signed({2'b00, opb_q[30:23]})
                     + 10'(EXP_BIAS);

    assign div_load = (state_q == StCheck) && !spec_hit;
    assign div_step = (state_q == StDiv);

    mant_divider_iter #(
        .QBITS (QBITS)
    ) u_mant_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i ({1'b1, opa_q[22:0]}),
        .divisor_i  ({1'b1, opb_q[22:0]}),
        .quot_o     (quot),
        .last_o     (div_last)
    );

    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift.
    always_comb begin
        exp_n  = quot[QBITS-1] ? expw_q : (expw_q - 10'sd1);
        mant_n = quot[QBITS-1] ? quot[QBITS-2 -: 23] : quot[QBITS-3 -: 23];
        norm_r = {sign, exp_n[7:0], mant_n};
        norm_c = CASE_NONE;
        if (exp_n >= 10'sd255) begin
            norm_r = {sign, 8'hFF, 23'd0};
            norm_c = sign ? CASE_NINF : CASE_PINF;
        end else if (exp_n <= 10'sd0) begin
            norm_r = {sign, 31'd0};
            norm_c = CASE_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            opa_q        <= '0;
            opb_q        <= '0;
            expw_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dataR        <= '0;
            casesspecial <= CASE_NONE;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        opa_q   <= dataA;
                        opb_q   <= dataB;
                        busy    <= 1'b1;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (spec_hit) begin
                        dataR        <= spec_r;
                        casesspecial <= spec_c;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state_q      <= StDone;
                    end else begin
                        expw_q  <= expw_calc;
                        state_q <= StDiv;
                    end
                end
                StDiv: begin
                    if (div_last) begin
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    dataR        <= norm_r;
                    casesspecial <= norm_c;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    state_q      <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_division_unit.sv
// Directed self-checking bench for division_unit: arithmetic, specials,
// range limits, handshake corner cases and asynchronous reset mid-operation.
module tb_division_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] dataR;
    logic [3:0]  casesspecial;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    division_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dataA        (dataA),
        .dataB        (dataB),
        .busy         (busy),
        .done         (done),
        .dataR        (dataR),
        .casesspecial (casesspecial)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Starts one operation and waits (bounded) for done; counts edges after the
    // sampling edge. pulse_at > 0 raises start with other operands at that edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] exp_c,
                          input int exp_lat, input int pulse_at);
        int  n;
        bit  seen;
        @(posedge clk); #1;
        dataA = a;
        dataB = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy"}, 32'(busy), 32'd1);
        seen = 1'b0;
        n    = 1;
        while (n <= 60 && !seen) begin
            if (pulse_at > 0 && n == pulse_at) begin
                start = 1'b1;
                dataA = 32'h3F80_0000;
                dataB = 32'h0000_0000;
            end
            if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
            @(posedge clk); #1;
            if (done) seen = 1'b1;
            else n++;
        end
        start = 1'b0;
        check({tag, ":lat"}, 32'(n), 32'(exp_lat));
        check({tag, ":dataR"}, dataR, exp_r);
        check({tag, ":case"}, 32'(casesspecial), 32'(exp_c));
        check({tag, ":busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n = 1'b0;
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        #12;
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:dataR", dataR, 32'd0);
        check("rst:case", 32'(casesspecial), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 0);
        run_op("-171/9.5", 32'hC32B_0000, 32'h4118_0000, 32'hC190_0000, 4'b0000, 27, 0);
        run_op("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 27, 0);
        run_op("1/0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1, 0);
        run_op("-inf/2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0010, 1, 0);
        run_op("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, 1, 0);
        run_op("inf/inf",  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001, 1, 0);
        run_op("0/nan",    32'h0000_0000, 32'h7FC0_0001, 32'h7FC0_0000, 4'b0001, 1, 0);
        run_op("-2/inf",   32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 4'b1000, 1, 0);
        run_op("ovf",      32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0100, 27, 0);
        run_op("unf",      32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b1000, 27, 0);
        run_op("pulse5",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 5);

        // start held high across done: second operation accepted only after DONE
        @(posedge clk); #1;
        dataA = 32'h40C0_0000;
        dataB = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk); #1;
        dataA = 32'h3F80_0000;
        dataB = 32'h0000_0000;
        seen = 1'b0;
        n    = 1;
        while (n <= 60 && !seen) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
            else n++;
        end
        check("hold:lat1", 32'(n), 32'd27);
        check("hold:dataR1", dataR, 32'h4040_0000);
        @(posedge clk); #1;
        check("hold:busy28", 32'(busy), 32'd0);
        check("hold:done28", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("hold:busy29", 32'(busy), 32'd1);
        start = 1'b0;
        @(posedge clk); #1;
        check("hold:done30", 32'(done), 32'd1);
        check("hold:dataR2", dataR, 32'h7F80_0000);
        check("hold:case2", 32'(casesspecial), 32'(4'b0100));

        // reset during the division iterations
        @(posedge clk); #1;
        dataA = 32'h40C0_0000;
        dataB = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
        end
        check("rstmid:busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid:busy", 32'(busy), 32'd0);
        check("rstmid:done", 32'(done), 32'd0);
        check("rstmid:dataR", dataR, 32'd0);
        check("rstmid:case", 32'(casesspecial), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("rstmid:no_done", 32'(seen), 32'd0);
        run_op("post_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
